// File: rtl/siso_ctrl_pkg.sv
// siso_ctrl_pkg: shared FSM encoding, idle line level and sizing helpers for the SISO loop controller.
// SISO_PARITY_EN adds one even-parity bit to every frame.
package siso_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
  localparam logic IDLE_LVL = 1'b0;
`ifdef SISO_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/siso_rx_deser.sv
// siso_rx_deser: MSB-first capture of the returning serial frame plus data compare and parity check.
// SISO_PARITY_EN: the frame's last bit is even parity over the word.
module siso_rx_deser
  import siso_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cap_en,
  input  logic             cap_last,
  input  logic             s_out,
  input  logic [WIDTH-1:0] ref_word,
  output logic [WIDTH-1:0] rx_word,
  output logic             mismatch,
  output logic             parity_err
);
  logic [N-1:0]     r_rx;
  logic [N-1:0]     w_rx_nx;
  logic [WIDTH-1:0] w_word_nx;
  logic             w_par_err;
  logic             r_mis;
  logic             r_par;
  assign w_rx_nx   = (r_rx << 1) | N'(s_out);
  assign w_word_nx = w_rx_nx[N-1 -: WIDTH];
`ifdef SISO_PARITY_EN
  assign w_par_err = (^w_word_nx) != w_rx_nx[0];
`else
  assign w_par_err = 1'b0;
`endif
  // flags are judged on the edge that captures the final bit, so use the post-shift view
  always_ff @(posedge clk) begin
    if (clear) begin
      r_rx  <= '0;
      r_mis <= 1'b0;
      r_par <= 1'b0;
    end else if (cap_en) begin
      r_rx <= w_rx_nx;
      if (cap_last) begin
        r_mis <= w_word_nx !== ref_word;
        r_par <= w_par_err;
      end
    end
  end
  assign rx_word    = r_rx[N-1 -: WIDTH];
  assign mismatch   = r_mis;
  assign parity_err = r_par;
endmodule

// File: rtl/siso_loop_ctrl.sv
// siso_loop_ctrl: loopback sequencer that serialises a word into a DEPTH-stage SISO chain and re-captures it.
// SISO_PARITY_EN appends an even-parity bit after the word LSB and checks it on return.
module siso_loop_ctrl
  import siso_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             s_in,
  input  logic             s_out,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             mismatch,
  output logic             parity_err
);
  localparam int N  = WIDTH + PAR_BITS;
  localparam int CW = clog2(N + DEPTH);
  state_t           r_state, w_state_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic             r_s_in, w_s_in_nx;
  logic [N-1:0]     r_sh, w_sh_nx, w_frame;
  logic [WIDTH-1:0] r_tx, w_tx_nx;
  logic             w_busy, w_cap_en, w_cap_last;
`ifdef SISO_PARITY_EN
  assign w_frame = {in_data, ^in_data};
`else
  assign w_frame = in_data;
`endif
  assign in_ready   = r_state == IDLE;
  assign out_valid  = r_state == DONE;
  assign s_in       = r_s_in;
  assign w_busy     = r_state == SEND || r_state == DRAIN;
  assign w_cap_en   = w_busy && r_cnt >= CW'(DEPTH);
  assign w_cap_last = r_cnt == CW'(N + DEPTH - 1);
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_s_in_nx  = r_s_in;
    w_sh_nx    = r_sh;
    w_tx_nx    = r_tx;
    case (r_state)
      IDLE: if (in_valid) begin
        w_state_nx = SEND;
        w_cnt_nx   = '0;
        w_s_in_nx  = w_frame[N-1];
        w_sh_nx    = w_frame << 1;
        w_tx_nx    = in_data;
      end
      SEND: begin
        w_cnt_nx   = r_cnt + CW'(1);
        w_state_nx = r_cnt == CW'(N - 1) ? DRAIN : SEND;
        w_s_in_nx  = r_cnt == CW'(N - 1) ? IDLE_LVL : r_sh[N-1];
        w_sh_nx    = r_sh << 1;
      end
      DRAIN: begin
        w_cnt_nx   = r_cnt + CW'(1);
        w_state_nx = w_cap_last ? DONE : DRAIN;
      end
      DONE: w_state_nx = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_s_in  <= IDLE_LVL;
      r_sh    <= '0;
      r_tx    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_s_in  <= w_s_in_nx;
      r_sh    <= w_sh_nx;
      r_tx    <= w_tx_nx;
    end
  end
  siso_rx_deser #(.WIDTH(WIDTH), .N(N)) u_rx (
    .clk       (clk),
    .clear     (clear),
    .cap_en    (w_cap_en),
    .cap_last  (w_cap_last),
    .s_out     (s_out),
    .ref_word  (r_tx),
    .rx_word   (out_data),
    .mismatch  (mismatch),
    .parity_err(parity_err)
  );
endmodule

// File: tb/tb_siso_loop_ctrl.sv
// tb_siso_loop_ctrl: loopback bench with a 4-stage SISO model, table-driven words plus corner sequences.
// SISO_PARITY_EN enables the parity-frame checks.
module tb_siso_loop_ctrl;
  localparam int DEPTH = 4;
`ifdef SISO_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 8 + PB;
  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       s_in;
  logic       s_out;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       mismatch;
  logic       parity_err;
  logic [3:0] r_siso = '0;
  logic       tb_force = 1'b0;
  logic       tb_fval = 1'b0;
  logic       tb_flip = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;
  typedef struct {
    logic [7:0] din;
    logic       frc;
    logic       fv;
    logic [7:0] ed;
    logic       em;
    logic       ep;
  } vec_t;
  vec_t tv[7];
  always #5 clk = ~clk;
  always @(posedge clk) r_siso <= {r_siso[2:0], s_in};
  assign s_out = tb_force ? tb_fval : (r_siso[3] ^ tb_flip);
  siso_loop_ctrl #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_in      (s_in),
    .s_out     (s_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mismatch  (mismatch),
    .parity_err(parity_err)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic ebit(input logic [7:0] d, input int k);
    return k < 8 ? d[7-k] : ^d;
  endfunction
  task automatic release_out(input string nm);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " ovalid_drop"}, out_valid, 1'b0);
    chk({nm, " rdy_back"}, in_ready, 1'b1);
  endtask
  task automatic wait_out(input string nm, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " ovalid"}, out_valid, 1'b1);
  endtask
  task automatic do_word(input string nm, input logic [7:0] din, input logic frc, input logic fv,
                         input int flip_at, input logic [7:0] ed, input logic em, input logic ep,
                         input bit rel);
    int lat;
    bit s_ok;
    @(negedge clk);
    chk({nm, " rdy"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = din;
    tb_force = frc;
    tb_fval  = fv;
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, " busy"}, in_ready, 1'b0);
    lat  = 0;
    s_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (lat < NB && s_in !== ebit(din, lat)) s_ok = 1'b0;
      tb_flip = lat == flip_at;
      @(negedge clk);
      lat++;
    end
    tb_flip  = 1'b0;
    tb_force = 1'b0;
    chk({nm, " s_in_seq"}, s_ok, 1'b1);
    chk({nm, " latency"}, lat, NB + DEPTH);
    chk({nm, " ovalid"}, out_valid, 1'b1);
    chk({nm, " data"}, out_data, ed);
    chk({nm, " mismatch"}, mismatch, em);
    chk({nm, " parity_err"}, parity_err, PB != 0 ? ep : 1'b0);
    if (rel) release_out(nm);
  endtask
  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int  lat;
    bit  ok;
    tv[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    tv[1] = '{8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tv[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};
    tv[3] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[4] = '{8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1};
    tv[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1};
    tv[6] = '{8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0};
    @(negedge clk);
    clear = 1'b0;
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset s_in", s_in, 1'b0);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset out_data", out_data, 8'h00);
    chk("reset mismatch", mismatch, 1'b0);
    chk("reset parity_err", parity_err, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stray out_ready", out_valid, 1'b0);
    for (int i = 0; i < 7; i++)
      do_word($sformatf("vec%0d", i), tv[i].din, tv[i].frc, tv[i].fv, -1, tv[i].ed, tv[i].em, tv[i].ep, 1'b1);
    do_word("hold", 8'h5A, 1'b0, 1'b0, -1, 8'h5A, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h11;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!out_valid || out_data !== 8'h5A || mismatch !== 1'b0 || in_ready) ok = 1'b0;
    end
    chk("hold stable", ok, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold drop ovalid", out_valid, 1'b0);
    chk("hold no bypass", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("hold next accepted", in_ready, 1'b0);
    wait_out("hold next", lat);
    chk("hold next latency", lat, NB + DEPTH);
    chk("hold next data", out_data, 8'h11);
    release_out("hold next");
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("abort in_ready", in_ready, 1'b1);
    chk("abort s_in", s_in, 1'b0);
    chk("abort out_data", out_data, 8'h00);
    chk("abort mismatch", mismatch, 1'b0);
    ok = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    chk("abort no out_valid", ok, 1'b0);
    do_word("after abort", 8'h3C, 1'b0, 1'b0, -1, 8'h3C, 1'b0, 1'b0, 1'b1);
`ifdef SISO_PARITY_EN
    do_word("parity", 8'h07, 1'b0, 1'b0, -1, 8'h07, 1'b0, 1'b0, 1'b1);
    do_word("parity flip", 8'h07, 1'b0, 1'b0, NB + DEPTH - 1, 8'h07, 1'b0, 1'b1, 1'b1);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
